// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between N_REQ requesters. At most one beat is
//   accepted per cycle. While no requester owns the port, grants rotate
//   round-robin starting after the last granted requester. A beat accepted
//   with its lock bit set keeps the port for that requester until it sends an
//   unlocked beat, or until it leaves the port unused for LOCK_MAX cycles.
//   Accepted beats are registered onto the memory port one cycle later. Reads
//   return their data to the originating requester RD_LAT+1 cycles after that.
//
// Ports
//   clk_i, rst_i   clock, synchronous active-high reset
//   req_valid_i    per-requester command valid
//   req_ready_o    per-requester accept (one-hot or zero)
//   req_we_i       per-requester write (1) / read (0)
//   req_lock_i     per-requester keep-ownership request
//   req_addr_i     packed addresses, requester n at slice n
//   req_dt_i       packed write data, requester n at slice n
//   rsp_valid_o    per-requester one-cycle read-data strobe
//   rsp_dt_o       shared read data, held between strobes
//   mem_en_o       memory enable
//   mem_we_o       memory write enable
//   mem_addr_o     memory address
//   mem_dt_o       memory write data
//   mem_dt_i       memory read data
//   lock_err_o     one-cycle pulse when a lock is revoked by timeout
module mem_port_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MEM_AW   = 16,
  parameter int MEM_DW   = 16,
  parameter int RD_LAT   = 2,
  parameter int LOCK_MAX = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ-1:0]         req_we_i,
  input  logic [N_REQ-1:0]         req_lock_i,
  input  logic [N_REQ*MEM_AW-1:0]  req_addr_i,
  input  logic [N_REQ*MEM_DW-1:0]  req_dt_i,
  output logic [N_REQ-1:0]         rsp_valid_o,
  output logic [MEM_DW-1:0]        rsp_dt_o,
  output logic                     mem_en_o,
  output logic                     mem_we_o,
  output logic [MEM_AW-1:0]        mem_addr_o,
  output logic [MEM_DW-1:0]        mem_dt_o,
  input  logic [MEM_DW-1:0]        mem_dt_i,
  output logic                     lock_err_o
);

  localparam int               IDX_W    = $clog2(N_REQ);
  localparam logic [7:0]       CNT_LAST = 8'(LOCK_MAX - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic {
    ST_IDLE,
    ST_OWN
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] ready;
  logic [IDX_W-1:0] acc_idx;
  logic             accept;
  logic             lock_err;

  // Round-robin pick: scan from the farthest candidate back to last+1 so the
  // nearest valid requester after last is the one left standing.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                               input logic [IDX_W-1:0] last);
    logic [N_REQ-1:0] oh;
    int               idx;
    oh = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (vld[idx]) begin
        oh      = '0;
        oh[idx] = 1'b1;
      end
    end
    return oh;
  endfunction

  // Grant: combinational from req_valid_i, suppressed while reset is asserted.
  always_comb begin
    ready = '0;
    if (!rst_i) begin
      if (state_q == ST_OWN) begin
        ready[owner_q] = req_valid_i[owner_q];
      end else begin
        ready = rr_pick(req_valid_i, last_q);
      end
    end
  end

  always_comb begin
    acc_idx = '0;
    for (int n = 0; n < N_REQ; n++) begin
      if (ready[n]) acc_idx = IDX_W'(n);
    end
  end

  assign accept      = |ready;
  assign req_ready_o = ready;

  // Ownership state: an accepted beat always restarts the idle count; the lock
  // bit of that beat decides whether its requester owns the port next cycle.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    lock_err = 1'b0;
    if (accept) begin
      last_d = acc_idx;
      cnt_d  = '0;
      if (req_lock_i[acc_idx]) begin
        state_d = ST_OWN;
        owner_d = acc_idx;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_OWN) begin
      if (cnt_q == CNT_LAST) begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        lock_err = !rst_i;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  assign lock_err_o = lock_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- stage boundary: accepted beat -> registered memory command ----
  logic              mem_en_q, mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [MEM_DW-1:0] mem_dt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dt_q   <= '0;
    end else begin
      mem_en_q <= accept;
      if (accept) begin
        mem_we_q   <= req_we_i[acc_idx];
        mem_addr_q <= req_addr_i[int'(acc_idx)*MEM_AW +: MEM_AW];
        mem_dt_q   <= req_dt_i[int'(acc_idx)*MEM_DW +: MEM_DW];
      end
    end
  end

  assign mem_en_o   = mem_en_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_dt_o   = mem_dt_q;

  // ---- stage boundary: read tracking, one slot per cycle until data returns ----
  // Slot k holds the read whose command is k cycles old on the memory port, so
  // slot RD_LAT lines up with its data on mem_dt_i.
  logic [RD_LAT:0]            rd_vld_q;
  logic [RD_LAT:0][IDX_W-1:0] rd_id_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_q <= '0;
    end else begin
      rd_vld_q <= {rd_vld_q[RD_LAT-1:0], accept & ~req_we_i[acc_idx]};
    end
  end

  always_ff @(posedge clk_i) begin
    rd_id_q <= {rd_id_q[RD_LAT-1:0], acc_idx};
  end

  // ---- stage boundary: registered response ----
  logic [N_REQ-1:0]  rsp_vld_q;
  logic [MEM_DW-1:0] rsp_dt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_vld_q <= '0;
      rsp_dt_q  <= '0;
    end else begin
      rsp_vld_q <= '0;
      if (rd_vld_q[RD_LAT]) begin
        rsp_vld_q <= ONE_HOT0 << rd_id_q[RD_LAT];
        rsp_dt_q  <= mem_dt_i;
      end
    end
  end

  assign rsp_valid_o = rsp_vld_q;
  assign rsp_dt_o    = rsp_dt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RL = 2;
  localparam int LM = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [N-1:0]      req_valid_i, req_ready_o, req_we_i, req_lock_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_dt_i;
  logic [N-1:0]      rsp_valid_o;
  logic [DW-1:0]     rsp_dt_o;
  logic              mem_en_o, mem_we_o;
  logic [AW-1:0]     mem_addr_o;
  logic [DW-1:0]     mem_dt_o, mem_dt_i;
  logic              lock_err_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .N_REQ(N), .MEM_AW(AW), .MEM_DW(DW), .RD_LAT(RL), .LOCK_MAX(LM)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_lock_i(req_lock_i),
    .req_addr_i(req_addr_i), .req_dt_i(req_dt_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dt_o(rsp_dt_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_dt_o(mem_dt_o), .mem_dt_i(mem_dt_i),
    .lock_err_o(lock_err_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // Memory attached to the port: RL-cycle read latency.
  logic [DW-1:0] ram  [0:65535];
  logic [DW-1:0] gold [0:65535];
  logic [DW-1:0] ram_q [RL];
  assign mem_dt_i = ram_q[RL-1];

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]  = dflt(AW'(i));
      gold[i] = dflt(AW'(i));
    end
  end

  always @(posedge clk) begin
    ram_q[0] <= ram[mem_addr_o];
    for (int i = 1; i < RL; i++) ram_q[i] <= ram_q[i-1];
    if (mem_en_o && mem_we_o) ram[mem_addr_o] <= mem_dt_o;
  end

  typedef struct {int cyc; bit en; bit chk_we; bit we; logic [AW-1:0] addr; logic [DW-1:0] dt;} mexp_t;
  typedef struct {int cyc; int id; logic [DW-1:0] dt;} rexp_t;
  typedef struct {int cyc; int idx;} glog_t;
  typedef struct {logic [N-1:0] vec; logic [DW-1:0] dt;} rlog_t;

  mexp_t mq[$];
  rexp_t rq[$];
  glog_t glog[$];
  rlog_t rlog[$];
  int    elog[$];

  // Reference model: ownership as an integer (-1 = nobody), rotation pointer,
  // idle-cycle count, and a golden memory updated in acceptance order.
  int            m_owner = -1;
  int            m_last  = N - 1;
  int            m_idle  = 0;
  logic [AW-1:0] h_addr  = '0;
  logic [DW-1:0] h_dt    = '0;

  always @(negedge clk) begin
    logic [N-1:0]  exp_rdy;
    logic          exp_err;
    int            g, di, i;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_rdy = '0;
    if (!rst_i) begin
      if (m_owner >= 0) begin
        if (req_valid_i[m_owner]) exp_rdy[m_owner] = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          i = (m_last + 1 + k) % N;
          if (req_valid_i[i]) begin
            exp_rdy[i] = 1'b1;
            break;
          end
        end
      end
    end
    g = -1;
    for (int n = 0; n < N; n++) if (exp_rdy[n]) g = n;
    exp_err = !rst_i && (m_owner >= 0) && (g < 0) && (m_idle + 1 == LM);
    chk("ready", 32'(req_ready_o), 32'(exp_rdy));
    chk("lock_err", 32'(lock_err_o), 32'(exp_err));

    di = -1;
    for (int n = 0; n < N; n++) if (req_ready_o[n] && req_valid_i[n]) di = n;
    if (di >= 0) glog.push_back('{cyc, di});
    if (lock_err_o) elog.push_back(cyc);

    if (rst_i) begin
      h_addr = '0;
      h_dt   = '0;
      mq.push_back('{cyc + 1, 1'b0, 1'b1, 1'b0, h_addr, h_dt});
      while (rq.size() > 0 && rq[rq.size()-1].cyc > cyc) void'(rq.pop_back());
      m_owner = -1;
      m_last  = N - 1;
      m_idle  = 0;
    end else if (g >= 0) begin
      a = req_addr_i[g*AW +: AW];
      d = req_dt_i[g*DW +: DW];
      h_addr = a;
      h_dt   = d;
      mq.push_back('{cyc + 1, 1'b1, 1'b1, req_we_i[g], a, d});
      if (req_we_i[g]) gold[a] = d;
      else rq.push_back('{cyc + 2 + RL, g, gold[a]});
      m_last = g;
      m_idle = 0;
      if (m_owner < 0) begin
        if (req_lock_i[g]) m_owner = g;
      end else if (!req_lock_i[g]) begin
        m_owner = -1;
      end
    end else begin
      mq.push_back('{cyc + 1, 1'b0, 1'b0, 1'b0, h_addr, h_dt});
      if (m_owner >= 0) begin
        m_idle++;
        if (m_idle == LM) begin
          m_owner = -1;
          m_idle  = 0;
        end
      end
    end
  end

  // Monitor: compares the memory port and the response port against queues.
  logic [DW-1:0] last_dt = '0;
  bit            prev_rst = 1'b0;

  always @(negedge clk) begin
    mexp_t me;
    rexp_t re;
    if (prev_rst) last_dt = '0;
    prev_rst = rst_i;

    if (mq.size() > 0 && mq[0].cyc == cyc) begin
      me = mq.pop_front();
      chk("mem_en", 32'(mem_en_o), 32'(me.en));
      chk("mem_addr", 32'(mem_addr_o), 32'(me.addr));
      chk("mem_dt", 32'(mem_dt_o), 32'(me.dt));
      if (me.chk_we) chk("mem_we", 32'(mem_we_o), 32'(me.we));
    end

    if (rsp_valid_o != '0) begin
      rlog.push_back('{rsp_valid_o, rsp_dt_o});
      if (rq.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
      end else begin
        re = rq.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(re.cyc));
        chk("rsp_vec", 32'(rsp_valid_o), 32'(1) << re.id);
        chk("rsp_dt", 32'(rsp_dt_o), 32'(re.dt));
        last_dt = re.dt;
      end
    end else begin
      if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        re = rq.pop_front();
        chk("rsp_missing", 32'(rsp_valid_o), 32'(1) << re.id);
      end
      chk("rsp_hold", 32'(rsp_dt_o), 32'(last_dt));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_all();
    req_valid_i = '0;
    req_we_i    = '0;
    req_lock_i  = '0;
  endtask

  task automatic set_req(input int n, input bit we, input bit lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid_i[n] = 1'b1;
    req_we_i[n]    = we;
    req_lock_i[n]  = lk;
    req_addr_i[n*AW +: AW] = a;
    req_dt_i[n*DW +: DW]   = d;
  endtask

  initial begin
    int t0, t1;
    rst_i      = 1'b1;
    clr_all();
    req_addr_i = '0;
    req_dt_i   = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // All four read continuously: grants rotate 0,1,2,3,0.
    glog.delete();
    t0 = cyc;
    repeat (5) begin
      for (int n = 0; n < N; n++) set_req(n, 1'b0, 1'b0, AW'(cyc * 4 + n), '0);
      next();
    end
    clr_all();
    chk("A_ngrants", 32'(glog.size()), 32'd5);
    if (glog.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("A_grant_idx", 32'(glog[i].idx), 32'(i % N));
        chk("A_grant_cyc", 32'(glog[i].cyc), 32'(t0 + i));
      end
    end
    repeat (8) next();

    // Write then read-back of the same address by another requester.
    rlog.delete();
    set_req(1, 1'b1, 1'b0, 16'h0010, 16'hBEEF);
    next();
    clr_all();
    set_req(2, 1'b0, 1'b0, 16'h0010, 16'h0000);
    next();
    clr_all();
    repeat (8) next();
    chk("B_nrsp", 32'(rlog.size()), 32'd1);
    if (rlog.size() >= 1) begin
      chk("B_rsp_vec", 32'(rlog[0].vec), 32'h4);
      chk("B_rsp_dt", 32'(rlog[0].dt), 32'hBEEF);
    end

    // Locked burst from requester 3 blocks requester 0.
    glog.delete();
    t0 = cyc;
    set_req(0, 1'b0, 1'b0, 16'h0020, '0);
    set_req(3, 1'b0, 1'b1, 16'h0030, '0);
    next();
    set_req(3, 1'b0, 1'b1, 16'h0031, '0);
    next();
    set_req(3, 1'b0, 1'b0, 16'h0032, '0);
    next();
    req_valid_i[3] = 1'b0;
    next();
    clr_all();
    chk("C_ngrants", 32'(glog.size()), 32'd4);
    if (glog.size() >= 4) begin
      chk("C_g0", 32'(glog[0].idx), 32'd3);
      chk("C_g1", 32'(glog[1].idx), 32'd3);
      chk("C_g2", 32'(glog[2].idx), 32'd3);
      chk("C_g3", 32'(glog[3].idx), 32'd0);
      chk("C_g3_cyc", 32'(glog[3].cyc), 32'(t0 + 3));
    end
    repeat (8) next();

    // Lock timeout: requester 2 locks then goes quiet while requester 1 waits.
    glog.delete();
    elog.delete();
    t0 = cyc;
    set_req(2, 1'b0, 1'b1, 16'h0040, '0);
    next();
    clr_all();
    set_req(1, 1'b0, 1'b0, 16'h0041, '0);
    repeat (5) next();
    clr_all();
    chk("D_nerr", 32'(elog.size()), 32'd1);
    if (elog.size() >= 1) chk("D_err_cyc", 32'(elog[0]), 32'(t0 + LM));
    chk("D_ngrants", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      chk("D_g0", 32'(glog[0].idx), 32'd2);
      chk("D_g1", 32'(glog[1].idx), 32'd1);
      chk("D_g1_cyc", 32'(glog[1].cyc), 32'(t0 + LM + 1));
    end
    repeat (8) next();

    // Reset with reads in flight.
    glog.delete();
    rlog.delete();
    set_req(0, 1'b0, 1'b0, 16'h0050, '0);
    set_req(1, 1'b0, 1'b0, 16'h0051, '0);
    next();
    next();
    clr_all();
    rst_i = 1'b1;
    next();
    rst_i = 1'b0;
    set_req(2, 1'b0, 1'b0, 16'h0052, '0);
    set_req(3, 1'b0, 1'b0, 16'h0053, '0);
    t1 = cyc;
    next();
    clr_all();
    repeat (8) next();
    chk("E_ngrants", 32'(glog.size()), 32'd3);
    if (glog.size() >= 3) begin
      chk("E_g0", 32'(glog[0].idx), 32'd0);
      chk("E_g1", 32'(glog[1].idx), 32'd1);
      chk("E_g2", 32'(glog[2].idx), 32'd2);
      chk("E_g2_cyc", 32'(glog[2].cyc), 32'(t1));
    end
    chk("E_nrsp", 32'(rlog.size()), 32'd1);
    if (rlog.size() >= 1) chk("E_rsp_vec", 32'(rlog[0].vec), 32'h4);

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      rst_i = ($urandom_range(0, 399) == 0);
      for (int n = 0; n < N; n++) begin
        req_valid_i[n] = $urandom_range(0, 1) == 1;
        req_we_i[n]    = $urandom_range(0, 2) == 0;
        req_lock_i[n]  = $urandom_range(0, 5) == 0;
        req_addr_i[n*AW +: AW] = AW'($urandom_range(0, 7));
        req_dt_i[n*DW +: DW]   = DW'($urandom);
      end
      next();
    end
    rst_i = 1'b0;
    clr_all();
    repeat (12) next();
    chk("drain_rsp", 32'(rq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
